alarme_despertador: RTL and testbench
=====================================

# alarme_despertador

Alarm unit for the digital clock. Sits directly downstream of the seconds/minutes/hours counters: consumes their BCD time digits and the 1 Hz enable pulse, holds a user-adjustable alarm setpoint (HH:MM), and drives ring/buzzer/snooze outputs. Its setpoint digits feed the existing BCD-to-7-segment converters for display.

## Interface
- RING_SECONDS, 60: ring duration in 1 Hz ticks before auto-stop (≥2).
- SNOOZE_SECONDS, 300: snooze duration in ticks before re-ringing (≥2).
- DEFAULT_HOUR, 6: setpoint hour after reset (0–23).
- DEFAULT_MIN, 0: setpoint minute after reset (0–59).
- alarme_clock  in  1  system clock (50 MHz); the only clock.
- alarme_reset  in  1  reset, synchronous, active-high.
- alarme_tick1hz  in  1  one-cycle pulse per second from the clock divider.
- alarme_t_h_msd / alarme_t_h_lsd  in  2 / 4  current hour BCD digits.
- alarme_t_m_msd / alarme_t_m_lsd  in  3 / 4  current minute BCD digits.
- alarme_t_s_msd / alarme_t_s_lsd  in  3 / 4  current second BCD digits.
- alarme_arm  in  1  level; 1 = alarm enabled.
- alarme_btn_h  in  1  one-cycle pulse (debounced upstream); increment setpoint hour.
- alarme_btn_m  in  1  one-cycle pulse; increment setpoint minute.
- alarme_stop  in  1  one-cycle pulse; cancel ring/snooze.
- alarme_snooze  in  1  one-cycle pulse; snooze while ringing.
- alarme_ring  out  1  high in RINGING.
- alarme_buzzer  out  1  1 Hz square wave while ringing, else 0.
- alarme_snoozing  out  1  high in SNOOZE.
- alarme_a_h_msd / alarme_a_h_lsd  out  2 / 4  setpoint hour BCD.
- alarme_a_m_msd / alarme_a_m_lsd  out  3 / 4  setpoint minute BCD.

## Operation
- All state is registered on alarme_clock; every register takes its reset value on any edge with alarme_reset=1, overriding all other inputs.
- Reset values: state IDLE, ring 0, buzzer 0, snoozing 0, counters 0, setpoint = DEFAULT_HOUR:DEFAULT_MIN in BCD, match_q = 1.
- match_now (combinational) = current HH:MM equals setpoint AND seconds = 00. match_q registers match_now every cycle. Trigger = match_now & ~match_q (rising edge → one trigger per occurrence; no trigger right after reset).
- Setpoint edit: btn_h increments hour BCD 00→…→23→00; btn_m increments minute 00→…→59→00, no carry into hour. Both pulses in one cycle both apply. Edits ignored in RINGING; allowed in IDLE and SNOOZE (snooze continues).
- FSM states IDLE, RINGING, SNOOZE:
  - IDLE: on trigger with arm=1 → RINGING, ring_cnt=0, buzzer=1.
  - RINGING: priority (high→low): arm=0 or stop → IDLE; snooze → SNOOZE, snz_cnt=0; tick with ring_cnt=RING_SECONDS-1 → IDLE; tick otherwise → ring_cnt+1, buzzer toggles.
  - SNOOZE: arm=0 or stop → IDLE; tick with snz_cnt=SNOOZE_SECONDS-1 → RINGING, ring_cnt=0, buzzer=1; tick otherwise → snz_cnt+1. Trigger ignored in SNOOZE/RINGING.
- Counter widths: $clog2 of the respective parameter; never exceed parameter-1.
- Buzzer forced 0 on every exit from RINGING.

## Timing
- Trigger registered: ring/buzzer rise on the first edge where inputs show matching time with match_q=0, i.e. 1 cycle after the counters present HH:MM:00.
- stop/snooze/arm=0 take effect on the edge sampling them (outputs change 1 cycle later).
- Ring lasts exactly RING_SECONDS ticks; exits on the edge sampling the RING_SECONDS-th tick.
- Setpoint outputs update 1 cycle after the button pulse.
- Tick and button in the same cycle are processed independently.
- Reset mid-RINGING/SNOOZE: next cycle IDLE, all outputs at reset values, setpoint restored to defaults.

## Test plan
- Reset, 6× btn_m pulses, 3× btn_h → setpoint 09:06; 24× btn_h from 23 → wraps to 23 again; btn_m at 59 → 00, hour unchanged.
- Setpoint 06:00, arm=1, drive time 05:59:59→06:00:00 → ring=1, buzzer=1 one cycle later; buzzer toggles per tick; after 60 ticks ring=0, no re-trigger during remaining 06:00:xx.
- Ringing, snooze pulse → ring=0, snoozing=1; after 300 ticks ring=1, snoozing=0, buzzer=1; stop pulse → IDLE, all 0.
- arm=0 at match time → no ring; arm drop mid-ring → IDLE next cycle.
- Stop and snooze same cycle while ringing → IDLE (stop wins); btn_h during RINGING → setpoint unchanged.
- alarme_reset asserted in SNOOZE with setpoint 09:06 → next cycle IDLE, outputs 0, setpoint 06:00; time already 06:00:00 at reset release → no ring.

Source files
------------

// File: rtl/alarme_despertador.sv
// Alarm unit: holds an editable HH:MM setpoint in BCD, compares it with the running time
// and sequences ring / snooze / idle, driving a 1 Hz buzzer while ringing.
//
// state   | meaning
// IDLE    | waiting for a rising match of time against the setpoint (armed)
// RINGING | ring high, buzzer toggles each tick, auto-stops after RING_SECONDS ticks
// SNOOZE  | ring silenced, re-rings after SNOOZE_SECONDS ticks
module alarme_despertador #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int DEFAULT_HOUR   = 6,
    parameter int DEFAULT_MIN    = 0
) (
    input  logic       alarme_clock,
    input  logic       alarme_reset,
    input  logic       alarme_tick1hz,
    input  logic [1:0] alarme_t_h_msd,
    input  logic [3:0] alarme_t_h_lsd,
    input  logic [2:0] alarme_t_m_msd,
    input  logic [3:0] alarme_t_m_lsd,
    input  logic [2:0] alarme_t_s_msd,
    input  logic [3:0] alarme_t_s_lsd,
    input  logic       alarme_arm,
    input  logic       alarme_btn_h,
    input  logic       alarme_btn_m,
    input  logic       alarme_stop,
    input  logic       alarme_snooze,
    output logic       alarme_ring,
    output logic       alarme_buzzer,
    output logic       alarme_snoozing,
    output logic [1:0] alarme_a_h_msd,
    output logic [3:0] alarme_a_h_lsd,
    output logic [2:0] alarme_a_m_msd,
    output logic [3:0] alarme_a_m_lsd
);

    localparam int RW = $clog2(RING_SECONDS);
    localparam int SW = $clog2(SNOOZE_SECONDS);

    localparam logic [1:0] DEF_H_MSD = 2'(DEFAULT_HOUR / 10);
    localparam logic [3:0] DEF_H_LSD = 4'(DEFAULT_HOUR % 10);
    localparam logic [2:0] DEF_M_MSD = 3'(DEFAULT_MIN / 10);
    localparam logic [3:0] DEF_M_LSD = 4'(DEFAULT_MIN % 10);

    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECONDS - 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          buzzer_q, buzzer_d;
    logic          match_q, match_d;
    logic [1:0]    h_msd_q, h_msd_d;
    logic [3:0]    h_lsd_q, h_lsd_d;
    logic [2:0]    m_msd_q, m_msd_d;
    logic [3:0]    m_lsd_q, m_lsd_d;
    logic          trigger;

    always_comb begin
        match_d = (alarme_t_h_msd == h_msd_q) && (alarme_t_h_lsd == h_lsd_q) &&
                  (alarme_t_m_msd == m_msd_q) && (alarme_t_m_lsd == m_lsd_q) &&
                  (alarme_t_s_msd == 3'd0)    && (alarme_t_s_lsd == 4'd0);
        // Rising edge only, so a held HH:MM:00 fires once
        trigger = match_d & ~match_q;
    end

    always_comb begin
        h_msd_d = h_msd_q;
        h_lsd_d = h_lsd_q;
        m_msd_d = m_msd_q;
        m_lsd_d = m_lsd_q;
        if (state_q != RINGING) begin
            if (alarme_btn_h) begin
                if (h_msd_q == 2'd2 && h_lsd_q == 4'd3) begin
                    h_msd_d = 2'd0;
                    h_lsd_d = 4'd0;
                end else if (h_lsd_q == 4'd9) begin
                    h_msd_d = h_msd_q + 2'd1;
                    h_lsd_d = 4'd0;
                end else begin
                    h_lsd_d = h_lsd_q + 4'd1;
                end
            end
            if (alarme_btn_m) begin
                if (m_lsd_q == 4'd9) begin
                    m_lsd_d = 4'd0;
                    m_msd_d = (m_msd_q == 3'd5) ? 3'd0 : m_msd_q + 3'd1;
                end else begin
                    m_lsd_d = m_lsd_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        buzzer_d   = buzzer_q;
        unique case (state_q)
            IDLE: begin
                if (trigger && alarme_arm) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    buzzer_d   = 1'b1;
                end
            end
            RINGING: begin
                if (!alarme_arm || alarme_stop) begin
                    state_d  = IDLE;
                    buzzer_d = 1'b0;
                end else if (alarme_snooze) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = '0;
                    buzzer_d  = 1'b0;
                end else if (alarme_tick1hz) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d  = IDLE;
                        buzzer_d = 1'b0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                        buzzer_d   = ~buzzer_q;
                    end
                end
            end
            SNOOZE: begin
                if (!alarme_arm || alarme_stop) begin
                    state_d = IDLE;
                end else if (alarme_tick1hz) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge alarme_clock) begin
        if (alarme_reset) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            match_q    <= 1'b1;
            h_msd_q    <= DEF_H_MSD;
            h_lsd_q    <= DEF_H_LSD;
            m_msd_q    <= DEF_M_MSD;
            m_lsd_q    <= DEF_M_LSD;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            buzzer_q   <= buzzer_d;
            match_q    <= match_d;
            h_msd_q    <= h_msd_d;
            h_lsd_q    <= h_lsd_d;
            m_msd_q    <= m_msd_d;
            m_lsd_q    <= m_lsd_d;
        end
    end

    assign alarme_ring     = (state_q == RINGING);
    assign alarme_snoozing = (state_q == SNOOZE);
    assign alarme_buzzer   = buzzer_q;
    assign alarme_a_h_msd  = h_msd_q;
    assign alarme_a_h_lsd  = h_lsd_q;
    assign alarme_a_m_msd  = m_msd_q;
    assign alarme_a_m_lsd  = m_lsd_q;

endmodule

// File: tb/tb_alarme_despertador.sv
// Bench for alarme_despertador: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model kept in integer hours/minutes and tick budgets.
module tb_alarme_despertador;

    localparam int RING_S = 60;
    localparam int SNZ_S  = 300;
    localparam int DEF_H  = 6;
    localparam int DEF_M  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, arm = 1'b0, bh = 1'b0, bm = 1'b0, stop = 1'b0, snz = 1'b0;
    int   th = 0, tm = 0, ts = 0;

    logic       ring, buzzer, snoozing;
    logic [1:0] a_h_msd;
    logic [3:0] a_h_lsd;
    logic [2:0] a_m_msd;
    logic [3:0] a_m_lsd;

    always #5 clk = ~clk;

    alarme_despertador #(
        .RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNZ_S),
        .DEFAULT_HOUR(DEF_H), .DEFAULT_MIN(DEF_M)
    ) dut (
        .alarme_clock(clk), .alarme_reset(rst), .alarme_tick1hz(tick),
        .alarme_t_h_msd(2'(th / 10)), .alarme_t_h_lsd(4'(th % 10)),
        .alarme_t_m_msd(3'(tm / 10)), .alarme_t_m_lsd(4'(tm % 10)),
        .alarme_t_s_msd(3'(ts / 10)), .alarme_t_s_lsd(4'(ts % 10)),
        .alarme_arm(arm), .alarme_btn_h(bh), .alarme_btn_m(bm),
        .alarme_stop(stop), .alarme_snooze(snz),
        .alarme_ring(ring), .alarme_buzzer(buzzer), .alarme_snoozing(snoozing),
        .alarme_a_h_msd(a_h_msd), .alarme_a_h_lsd(a_h_lsd),
        .alarme_a_m_msd(a_m_msd), .alarme_a_m_lsd(a_m_lsd)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bcd_hm(input int h, input int m);
        return 32'({2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)});
    endfunction

    // Model: mode 0 idle, 1 ringing, 2 snoozing; budgets count ticks still to go
    int m_mode = 0, m_ring_left = 0, m_snz_left = 0;
    int m_hour = DEF_H, m_min = DEF_M;
    bit m_prev_match = 1'b1;

    function automatic logic [31:0] setpoint_dut();
        return 32'({a_h_msd, a_h_lsd, a_m_msd, a_m_lsd});
    endfunction

    task automatic cycle();
        bit mn, trig;
        int nh, nm;
        if (rst) begin
            m_mode = 0; m_ring_left = 0; m_snz_left = 0;
            m_hour = DEF_H; m_min = DEF_M; m_prev_match = 1'b1;
        end else begin
            mn = (th == m_hour) && (tm == m_min) && (ts == 0);
            trig = mn && !m_prev_match;
            m_prev_match = mn;
            nh = m_hour; nm = m_min;
            if (m_mode != 1) begin
                if (bh) nh = (m_hour + 1) % 24;
                if (bm) nm = (m_min + 1) % 60;
            end
            case (m_mode)
                0: if (trig && arm) begin m_mode = 1; m_ring_left = RING_S; end
                1: begin
                    if (!arm || stop) m_mode = 0;
                    else if (snz) begin m_mode = 2; m_snz_left = SNZ_S; end
                    else if (tick) begin
                        m_ring_left--;
                        if (m_ring_left == 0) m_mode = 0;
                    end
                end
                default: begin
                    if (!arm || stop) m_mode = 0;
                    else if (tick) begin
                        m_snz_left--;
                        if (m_snz_left == 0) begin m_mode = 1; m_ring_left = RING_S; end
                    end
                end
            endcase
            m_hour = nh; m_min = nm;
        end
        @(posedge clk);
        #1;
        // Buzzer is high on even elapsed-tick counts of the current ring
        check("outs", 32'({ring, buzzer, snoozing}),
              32'({m_mode == 1, m_mode == 1 && ((RING_S - m_ring_left) % 2 == 0), m_mode == 2}));
        check("setpoint", setpoint_dut(), bcd_hm(m_hour, m_min));
    endtask

    task automatic advance_time();
        ts++;
        if (ts == 60) begin ts = 0; tm++; end
        if (tm == 60) begin tm = 0; th = (th + 1) % 24; end
    endtask

    task automatic sec();
        tick = 1'b1; advance_time(); cycle();
        tick = 1'b0; cycle();
    endtask

    task automatic press_h(input int n);
        for (int i = 0; i < n; i++) begin bh = 1'b1; cycle(); bh = 1'b0; cycle(); end
    endtask

    task automatic press_m(input int n);
        for (int i = 0; i < n; i++) begin bm = 1'b1; cycle(); bm = 1'b0; cycle(); end
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    endtask

    // Time one second before the setpoint, then tick into HH:MM:00
    task automatic ring_now(input int h, input int m);
        th = (m == 0) ? (h + 23) % 24 : h;
        tm = (m + 59) % 60;
        ts = 59;
        cycle();
        sec();
    endtask

    initial begin
        th = 5; tm = 0; ts = 0;
        do_reset();
        check("reset_outs", 32'({ring, buzzer, snoozing}), 32'd0);
        check("reset_setpt", setpoint_dut(), bcd_hm(6, 0));

        press_m(6); press_h(3);
        check("sp_0906", setpoint_dut(), bcd_hm(9, 6));
        press_h(14);
        check("sp_2306", setpoint_dut(), bcd_hm(23, 6));
        press_h(24);
        check("hour_wrap", setpoint_dut(), bcd_hm(23, 6));
        press_m(53);
        check("sp_2359", setpoint_dut(), bcd_hm(23, 59));
        press_m(1);
        check("min_wrap", setpoint_dut(), bcd_hm(23, 0));
        bh = 1'b1; bm = 1'b1; cycle(); bh = 1'b0; bm = 1'b0;
        check("both_btn", setpoint_dut(), bcd_hm(0, 1));

        // Full ring at 06:00, auto-stop after the 60th tick
        do_reset();
        arm = 1'b1;
        th = 5; tm = 59; ts = 59; cycle();
        tick = 1'b1; advance_time(); cycle();
        check("ring_rise", 32'({ring, buzzer}), 32'b11);
        tick = 1'b0; cycle();
        for (int i = 0; i < RING_S - 1; i++) sec();
        check("ring_last", 32'(ring), 32'd1);
        sec();
        check("ring_done", 32'({ring, buzzer}), 32'd0);
        for (int i = 0; i < 5; i++) sec();

        // Held 06:00:00 after stop must not retrigger
        ring_now(6, 0);
        stop = 1'b1; cycle(); stop = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("no_retrig", 32'(ring), 32'd0);

        // Snooze then re-ring, then stop
        ring_now(6, 0);
        sec(); sec();
        snz = 1'b1; cycle(); snz = 1'b0;
        check("snoozing", 32'({ring, snoozing}), 32'b01);
        press_m(2);
        for (int i = 0; i < SNZ_S; i++) sec();
        check("rering", 32'({ring, buzzer, snoozing}), 32'b110);
        bh = 1'b1; cycle(); bh = 1'b0;
        check("btn_in_ring", setpoint_dut(), bcd_hm(6, 2));
        stop = 1'b1; snz = 1'b1; cycle(); stop = 1'b0; snz = 1'b0;
        check("stop_wins", 32'({ring, buzzer, snoozing}), 32'd0);

        // Disarmed at match; disarm mid-ring
        arm = 1'b0; ring_now(6, 2); cycle();
        check("disarmed", 32'(ring), 32'd0);
        arm = 1'b1; ring_now(6, 2); sec();
        arm = 1'b0; cycle(); arm = 1'b1;
        check("arm_drop", 32'({ring, buzzer}), 32'd0);

        // Reset during snooze with setpoint 09:06, time already at default alarm time
        do_reset(); press_m(6); press_h(3);
        ring_now(9, 6);
        snz = 1'b1; cycle(); snz = 1'b0;
        th = 6; tm = 0; ts = 0;
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_snz", 32'({ring, buzzer, snoozing}), 32'd0);
        check("rst_setpt", setpoint_dut(), bcd_hm(6, 0));
        for (int i = 0; i < 5; i++) cycle();
        check("no_ring_rel", 32'(ring), 32'd0);

        // Random phase
        for (int i = 0; i < 6000; i++) begin
            case ($urandom_range(0, 199))
                0, 1: begin th = (m_min == 0) ? (m_hour + 23) % 24 : m_hour;
                            tm = (m_min + 59) % 60; ts = 59; end
                2: begin th = m_hour; tm = m_min; ts = 0; end
                3: begin th = $urandom_range(0, 23); tm = $urandom_range(0, 59);
                         ts = $urandom_range(0, 59); end
                default: ;
            endcase
            rst  = ($urandom_range(0, 799) == 0);
            arm  = ($urandom_range(0, 99) != 0);
            tick = ($urandom_range(0, 2) == 0);
            if (tick) advance_time();
            bh   = ($urandom_range(0, 24) == 0);
            bm   = ($urandom_range(0, 24) == 0);
            stop = ($urandom_range(0, 299) == 0);
            snz  = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0; tick = 1'b0; bh = 1'b0; bm = 1'b0; stop = 1'b0; snz = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
